rmt_repair_ctrl: RTL and testbench
==================================

Name: rmt_repair_ctrl

Overview:
- Sequences restoration of the speculative rename map table after a recovery, such as a branch mispredict or an exception.
- Walks the architectural map table (AMT) N_REPAIR_PACKETS entries per cycle.
- Drives the RMT repair port (repairFlag/repairAddr/repairData) and holds rename stalled until the copy completes.
- Sits between the commit-side AMT and the rename stage.

Parameters:
- SIZE_RMT, 64, number of logical registers / RMT entries; must be a multiple of N_REPAIR_PACKETS (elaboration-time $error otherwise).
- SIZE_RMT_LOG, 6, log2(SIZE_RMT).
- SIZE_PHYSICAL_LOG, 7, physical register tag width.
- N_REPAIR_PACKETS, 4, RMT entries repaired per cycle (lanes).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- recoverFlag_i  in  1  one-cycle pulse: start (or restart) a repair.
- amtRdAddr_o  out  N_REPAIR_PACKETS*SIZE_RMT_LOG  AMT read addresses, lane k in bits [k*SIZE_RMT_LOG +: SIZE_RMT_LOG].
- amtRdData_i  in  N_REPAIR_PACKETS*SIZE_PHYSICAL_LOG  AMT read data, combinational, same cycle as address.
- repairFlag_o  out  1  repair beat valid to RMT.
- repairAddr_o  out  N_REPAIR_PACKETS*SIZE_RMT_LOG  RMT write addresses.
- repairData_o  out  N_REPAIR_PACKETS*SIZE_PHYSICAL_LOG  RMT write data (physical tags).
- repairBusy_o  out  1  rename must stall while high.
- repairDone_o  out  1  one-cycle pulse with the final beat.

Behaviour:
- Beats B = SIZE_RMT/N_REPAIR_PACKETS. beatCnt is SIZE_RMT_LOG bits wide and counts 0..B-1.
- States:
  - IDLE: on recoverFlag_i go to READ with beatCnt=0.
  - READ: each cycle drive amtRdAddr lane k = beatCnt*N_REPAIR_PACKETS + k and register the addresses plus amtRdData_i into the repair output registers (repairFlag_o=1 next cycle). At beatCnt==B-1, go to IDLE. Otherwise beatCnt++.
- amtRdAddr_o is 0 in IDLE.
- Latency:
  - Read at cycle t appears on repairAddr_o/repairData_o/repairFlag_o at t+1.
  - recoverFlag_i sampled at edge T gives READ during cycles T+1..T+B and repair beats during T+2..T+B+1.
- repairDone_o is registered and asserted together with the beat carrying beatCnt==B-1.
- repairBusy_o = recoverFlag_i | (state!=IDLE) | repairFlag_o. It is combinational, so rename stalls in the recovery cycle itself and through the last beat.
- recoverFlag_i while in READ: restart, with beatCnt=0 next cycle. The beat already registered this cycle is still issued (RMT writes are idempotent AMT copies). repairDone_o must not pulse for the aborted walk.
- recoverFlag_i in the same cycle as the final READ beat: that final beat is still issued with no done pulse, then READ restarts at beatCnt=0.
- recoverFlag_i coincident with reset: reset wins.
- reset, including mid-walk: state=IDLE, beatCnt=0, repairFlag_o=0, repairAddr_o=0, repairData_o=0, repairDone_o=0. repairBusy_o=0 unless recoverFlag_i is high.
- Output registers hold their last value when repairFlag_o=0. Consumers must qualify with repairFlag_o.

Optional Feature:
- Macro: RMT_REPAIR_PERF_EN.
- Defined: adds outputs repairEvents_o (32b, +1 per accepted recoverFlag_i, including restarts) and repairCycles_o (32b, +1 per cycle repairBusy_o=1). Both are zero on reset and saturate at all-ones.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, amtRdAddr_o=0.
- SIZE_RMT=64, N=4, AMT[i]=i+32, single recoverFlag_i at T -> repairFlag_o high T+2..T+17, 16 beats. Beat j carries addr {4j..4j+3} and data {4j+32..4j+35}. repairDone_o only at T+17. repairBusy_o high T..T+17.
- Second recoverFlag_i at T+6 -> beat 4 still issued at T+6, walk restarts (beat 0 at T+8), repairDone_o only at T+23, no pulse at T+17.
- reset asserted at T+5 mid-walk -> next cycle state IDLE, repairFlag_o=0, repairBusy_o=0, no repairDone_o.
- recoverFlag_i coincident with the final READ cycle (T+16) -> beat 15 issued at T+17 without done, fresh walk completes with done at T+33.
- With RMT_REPAIR_PERF_EN: two non-overlapping recoveries -> repairEvents_o=2, repairCycles_o=36.

Source files
------------

// File: rtl/rmt_repair_ctrl.sv
// -----------------------------------------------------------------------------
// rmt_repair_ctrl
//
// Restores the speculative rename map table (RMT) after a recovery event
// (branch mispredict, exception). It copies the architectural map table (AMT)
// into the RMT, N_REPAIR_PACKETS entries per cycle. While the copy is in
// progress, rename is held stalled through repairBusy_o.
//
// Walk timing, where T is the cycle in which recoverFlag_i is high:
//   READ state         : cycles T+1 .. T+B        (B = SIZE_RMT / N_REPAIR_PACKETS)
//   repair beats       : cycles T+2 .. T+B+1      (one cycle behind the AMT read)
//   repairDone_o       : cycle  T+B+1             (with the final beat)
//   repairBusy_o       : cycles T   .. T+B+1
//
// Ports
//   clk             in   core clock
//   reset           in   synchronous, active-high reset
//   recoverFlag_i   in   one-cycle pulse that starts (or restarts) a repair walk
//   amtRdAddr_o     out  AMT read addresses, lane k at [k*SIZE_RMT_LOG +: SIZE_RMT_LOG];
//                        zero while idle
//   amtRdData_i     in   AMT read data, combinational, returned in the same cycle
//   repairFlag_o    out  repair beat valid toward the RMT
//   repairAddr_o    out  RMT write addresses, one per lane
//   repairData_o    out  RMT write data (physical tags), one per lane
//   repairBusy_o    out  rename must stall while high (combinational)
//   repairDone_o    out  one-cycle pulse that accompanies the final beat
//
// Optional feature (compile-time macro RMT_REPAIR_PERF_EN)
//   repairEvents_o  out  32b saturating count of accepted recoverFlag_i pulses
//   repairCycles_o  out  32b saturating count of cycles with repairBusy_o high
//   With the macro undefined, these ports and counters are absent.
// -----------------------------------------------------------------------------
module rmt_repair_ctrl #(
    parameter int SIZE_RMT          = 64,
    parameter int SIZE_RMT_LOG      = 6,
    parameter int SIZE_PHYSICAL_LOG = 7,
    parameter int N_REPAIR_PACKETS  = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          recoverFlag_i,
    output logic [N_REPAIR_PACKETS*SIZE_RMT_LOG-1:0]      amtRdAddr_o,
    input  logic [N_REPAIR_PACKETS*SIZE_PHYSICAL_LOG-1:0] amtRdData_i,
    output logic                                          repairFlag_o,
    output logic [N_REPAIR_PACKETS*SIZE_RMT_LOG-1:0]      repairAddr_o,
    output logic [N_REPAIR_PACKETS*SIZE_PHYSICAL_LOG-1:0] repairData_o,
    output logic                                          repairBusy_o,
    output logic                                          repairDone_o
`ifdef RMT_REPAIR_PERF_EN
    ,
    output logic [31:0]                                   repairEvents_o,
    output logic [31:0]                                   repairCycles_o
`endif
);

    localparam int NUM_BEATS = SIZE_RMT / N_REPAIR_PACKETS;
    localparam logic [SIZE_RMT_LOG-1:0] LAST_BEAT   = SIZE_RMT_LOG'(NUM_BEATS - 1);
    localparam logic [SIZE_RMT_LOG-1:0] LANE_STRIDE = SIZE_RMT_LOG'(N_REPAIR_PACKETS);

    // A partial final beat would leave RMT entries unrepaired, so refuse to
    // elaborate such a configuration.
    if ((SIZE_RMT % N_REPAIR_PACKETS) != 0) begin : gParamCheck
        $error("rmt_repair_ctrl: SIZE_RMT (%0d) must be a multiple of N_REPAIR_PACKETS (%0d)",
               SIZE_RMT, N_REPAIR_PACKETS);
    end

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t                                  state;
    logic [SIZE_RMT_LOG-1:0]                 beatCnt;
    logic [N_REPAIR_PACKETS*SIZE_RMT_LOG-1:0] walkAddr;
    logic                                    readActive;

    assign readActive = (state == READ);

    // Lane k of beat n reads AMT entry n*N_REPAIR_PACKETS + k.
    genvar gi;
    generate
        for (gi = 0; gi < N_REPAIR_PACKETS; gi++) begin : gLane
            assign walkAddr[gi*SIZE_RMT_LOG +: SIZE_RMT_LOG] =
                (beatCnt * LANE_STRIDE) + SIZE_RMT_LOG'(gi);
        end
    endgenerate

    // AMT addresses are forced to zero while idle so the AMT read port sees no
    // spurious activity between walks.
    assign amtRdAddr_o = readActive ? walkAddr : '0;

    // Combinational so that rename already stalls in the cycle that carries
    // the recovery pulse, and stays stalled until the last beat has left.
    assign repairBusy_o = recoverFlag_i | readActive | repairFlag_o;

    // Walk sequencer with registered repair outputs. Each READ cycle captures
    // its addresses and the AMT data into the output registers, so a beat
    // always appears exactly one cycle after its AMT read. This holds even
    // when a restart arrives in the same cycle: RMT writes are idempotent copies
    // of the AMT, so finishing the in-flight beat is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            beatCnt      <= '0;
            repairFlag_o <= 1'b0;
            repairAddr_o <= '0;
            repairData_o <= '0;
            repairDone_o <= 1'b0;
        end else begin
            repairFlag_o <= readActive;
            repairDone_o <= 1'b0;

            // The output registers hold their value between walks; consumers
            // qualify them with repairFlag_o.
            if (readActive) begin
                repairAddr_o <= walkAddr;
                repairData_o <= amtRdData_i;
            end

            case (state)
                IDLE: begin
                    if (recoverFlag_i) begin
                        state   <= READ;
                        beatCnt <= '0;
                    end
                end
                READ: begin
                    if (recoverFlag_i) begin
                        // Restart. Done is not pulsed for the aborted walk,
                        // even when the restart lands on its final beat.
                        beatCnt <= '0;
                    end else if (beatCnt == LAST_BEAT) begin
                        state        <= IDLE;
                        beatCnt      <= '0;
                        repairDone_o <= 1'b1;
                    end else begin
                        beatCnt <= beatCnt + SIZE_RMT_LOG'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    beatCnt <= '0;
                end
            endcase
        end
    end

`ifdef RMT_REPAIR_PERF_EN
    // Performance counters. Both saturate instead of wrapping, so a long run
    // never reports a misleadingly small value.
    always_ff @(posedge clk) begin
        if (reset) begin
            repairEvents_o <= '0;
            repairCycles_o <= '0;
        end else begin
            if (recoverFlag_i && (repairEvents_o != '1)) begin
                repairEvents_o <= repairEvents_o + 32'd1;
            end
            if (repairBusy_o && (repairCycles_o != '1)) begin
                repairCycles_o <= repairCycles_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rmt_repair_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rmt_repair_ctrl
//
// Directed testbench for rmt_repair_ctrl with the default configuration
// (SIZE_RMT=64, N_REPAIR_PACKETS=4, so 16 beats per walk). The AMT is modelled
// combinationally with AMT[i] = i + 32. In every task, cycle 0 is the cycle in
// which the first recoverFlag_i is driven. Outputs are sampled on the falling
// edge, and inputs change 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_rmt_repair_ctrl;

    localparam int SIZE_RMT          = 64;
    localparam int SIZE_RMT_LOG      = 6;
    localparam int SIZE_PHYSICAL_LOG = 7;
    localparam int N                 = 4;
    localparam int AW                = N * SIZE_RMT_LOG;
    localparam int DW                = N * SIZE_PHYSICAL_LOG;

    logic          clk;
    logic          reset;
    logic          recoverFlag;
    logic [AW-1:0] amtRdAddr;
    logic [DW-1:0] amtRdData;
    logic          repairFlag;
    logic [AW-1:0] repairAddr;
    logic [DW-1:0] repairData;
    logic          repairBusy;
    logic          repairDone;
`ifdef RMT_REPAIR_PERF_EN
    logic [31:0]   repairEvents;
    logic [31:0]   repairCycles;
`endif

    int errors = 0;
    int checks = 0;

    rmt_repair_ctrl #(
        .SIZE_RMT          (SIZE_RMT),
        .SIZE_RMT_LOG      (SIZE_RMT_LOG),
        .SIZE_PHYSICAL_LOG (SIZE_PHYSICAL_LOG),
        .N_REPAIR_PACKETS  (N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .recoverFlag_i (recoverFlag),
        .amtRdAddr_o   (amtRdAddr),
        .amtRdData_i   (amtRdData),
        .repairFlag_o  (repairFlag),
        .repairAddr_o  (repairAddr),
        .repairData_o  (repairData),
        .repairBusy_o  (repairBusy),
        .repairDone_o  (repairDone)
`ifdef RMT_REPAIR_PERF_EN
        ,
        .repairEvents_o(repairEvents),
        .repairCycles_o(repairCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AMT model: entry i holds physical tag i + 32.
    always_comb begin
        amtRdData = '0;
        for (int k = 0; k < N; k++) begin
            amtRdData[k*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG] =
                7'(amtRdAddr[k*SIZE_RMT_LOG +: SIZE_RMT_LOG]) + 7'd32;
        end
    end

    // Expected lane vectors for beat j: addresses 4j..4j+3 and data 4j+32..4j+35.
    function automatic logic [AW-1:0] beatAddr(input int j);
        logic [AW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*SIZE_RMT_LOG +: SIZE_RMT_LOG] = 6'(4*j + k);
        return v;
    endfunction

    function automatic logic [DW-1:0] beatData(input int j);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG] = 7'(4*j + k + 32);
        return v;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        recoverFlag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({repairFlag, repairBusy, repairDone} !== 3'b000) begin
                errors++;
                $display("FAIL reset_ctrl cycle %0d: got flag/busy/done=%b required 000", i, {repairFlag, repairBusy, repairDone});
            end
            checks++;
            if (repairAddr !== '0 || repairData !== '0) begin
                errors++;
                $display("FAIL reset_regs cycle %0d: got addr=%h data=%h required 0", i, repairAddr, repairData);
            end
            checks++;
            if (amtRdAddr !== '0) begin
                errors++;
                $display("FAIL reset_amtaddr cycle %0d: got %h required 0", i, amtRdAddr);
            end
            nextCycle();
        end
        $display("test_reset: 5 idle cycles checked");
    endtask

    task automatic test_single_walk();
        logic expBusy, expFlag, expDone;
        int   j, r;
        for (int i = 0; i < 21; i++) begin
            recoverFlag = (i == 0);
            expBusy = (i <= 17);
            expFlag = (i >= 2 && i <= 17);
            expDone = (i == 17);
            j = i - 2;
            r = i - 1;
            @(negedge clk);
            checks++;
            if ({repairBusy, repairFlag, repairDone} !== {expBusy, expFlag, expDone}) begin
                errors++;
                $display("FAIL single_ctrl cycle %0d: got busy/flag/done=%b required %b", i, {repairBusy, repairFlag, repairDone}, {expBusy, expFlag, expDone});
            end
            if (expFlag) begin
                checks++;
                if (repairAddr !== beatAddr(j) || repairData !== beatData(j)) begin
                    errors++;
                    $display("FAIL single_beat cycle %0d: got addr=%h data=%h required addr=%h data=%h", i, repairAddr, repairData, beatAddr(j), beatData(j));
                end
            end
            checks++;
            if (amtRdAddr !== ((i >= 1 && i <= 16) ? beatAddr(r) : '0)) begin
                errors++;
                $display("FAIL single_amtaddr cycle %0d: got %h required %h", i, amtRdAddr, (i >= 1 && i <= 16) ? beatAddr(r) : '0);
            end
            nextCycle();
        end
        recoverFlag = 1'b0;
        $display("test_single_walk: 16 beats, done at cycle 17");
    endtask

    task automatic test_restart();
        logic expBusy, expFlag, expDone, rd;
        int   j, r;
        for (int i = 0; i < 26; i++) begin
            recoverFlag = (i == 0 || i == 6);
            expBusy = (i <= 23);
            expFlag = (i >= 2 && i <= 23);
            expDone = (i == 23);
            j = (i <= 7) ? i - 2 : i - 8;
            rd = (i >= 1 && i <= 22);
            r = (i <= 6) ? i - 1 : i - 7;
            @(negedge clk);
            checks++;
            if ({repairBusy, repairFlag, repairDone} !== {expBusy, expFlag, expDone}) begin
                errors++;
                $display("FAIL restart_ctrl cycle %0d: got busy/flag/done=%b required %b", i, {repairBusy, repairFlag, repairDone}, {expBusy, expFlag, expDone});
            end
            if (expFlag) begin
                checks++;
                if (repairAddr !== beatAddr(j) || repairData !== beatData(j)) begin
                    errors++;
                    $display("FAIL restart_beat cycle %0d: got addr=%h data=%h required addr=%h data=%h", i, repairAddr, repairData, beatAddr(j), beatData(j));
                end
            end
            checks++;
            if (amtRdAddr !== (rd ? beatAddr(r) : '0)) begin
                errors++;
                $display("FAIL restart_amtaddr cycle %0d: got %h required %h", i, amtRdAddr, rd ? beatAddr(r) : '0);
            end
            nextCycle();
        end
        recoverFlag = 1'b0;
        $display("test_restart: restart at cycle 6, done at cycle 23");
    endtask

    task automatic test_restart_last_beat();
        logic expBusy, expFlag, expDone, rd;
        int   j, r;
        for (int i = 0; i < 36; i++) begin
            recoverFlag = (i == 0 || i == 16);
            expBusy = (i <= 33);
            expFlag = (i >= 2 && i <= 33);
            expDone = (i == 33);
            j = (i <= 17) ? i - 2 : i - 18;
            rd = (i >= 1 && i <= 32);
            r = (i <= 16) ? i - 1 : i - 17;
            @(negedge clk);
            checks++;
            if ({repairBusy, repairFlag, repairDone} !== {expBusy, expFlag, expDone}) begin
                errors++;
                $display("FAIL lastbeat_ctrl cycle %0d: got busy/flag/done=%b required %b", i, {repairBusy, repairFlag, repairDone}, {expBusy, expFlag, expDone});
            end
            if (expFlag) begin
                checks++;
                if (repairAddr !== beatAddr(j) || repairData !== beatData(j)) begin
                    errors++;
                    $display("FAIL lastbeat_beat cycle %0d: got addr=%h data=%h required addr=%h data=%h", i, repairAddr, repairData, beatAddr(j), beatData(j));
                end
            end
            checks++;
            if (amtRdAddr !== (rd ? beatAddr(r) : '0)) begin
                errors++;
                $display("FAIL lastbeat_amtaddr cycle %0d: got %h required %h", i, amtRdAddr, rd ? beatAddr(r) : '0);
            end
            nextCycle();
        end
        recoverFlag = 1'b0;
        $display("test_restart_last_beat: restart on final read, done at cycle 33");
    endtask

    task automatic test_reset_mid_walk();
        logic expBusy, expFlag;
        for (int i = 0; i < 24; i++) begin
            recoverFlag = (i == 0);
            reset = (i == 5);
            expBusy = (i <= 5);
            expFlag = (i >= 2 && i <= 5);
            @(negedge clk);
            checks++;
            if ({repairBusy, repairFlag, repairDone} !== {expBusy, expFlag, 1'b0}) begin
                errors++;
                $display("FAIL midreset_ctrl cycle %0d: got busy/flag/done=%b required %b", i, {repairBusy, repairFlag, repairDone}, {expBusy, expFlag, 1'b0});
            end
            if (expFlag) begin
                checks++;
                if (repairAddr !== beatAddr(i - 2) || repairData !== beatData(i - 2)) begin
                    errors++;
                    $display("FAIL midreset_beat cycle %0d: got addr=%h data=%h required addr=%h data=%h", i, repairAddr, repairData, beatAddr(i - 2), beatData(i - 2));
                end
            end
            if (i >= 6) begin
                checks++;
                if (repairAddr !== '0 || repairData !== '0 || amtRdAddr !== '0) begin
                    errors++;
                    $display("FAIL midreset_regs cycle %0d: got addr=%h data=%h amt=%h required 0", i, repairAddr, repairData, amtRdAddr);
                end
            end
            nextCycle();
        end
        reset = 1'b0;
        recoverFlag = 1'b0;
        $display("test_reset_mid_walk: reset at cycle 5 aborted the walk");
    endtask

    task automatic test_reset_with_recover();
        reset = 1'b1;
        recoverFlag = 1'b1;
        @(negedge clk);
        checks++;
        if (repairBusy !== 1'b1) begin
            errors++;
            $display("FAIL rstrec_busy: got %b required 1", repairBusy);
        end
        nextCycle();
        reset = 1'b0;
        recoverFlag = 1'b0;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({repairBusy, repairFlag, repairDone} !== 3'b000 || amtRdAddr !== '0) begin
                errors++;
                $display("FAIL rstrec_idle cycle %0d: got busy/flag/done=%b amt=%h required 000 and 0", i, {repairBusy, repairFlag, repairDone}, amtRdAddr);
            end
            nextCycle();
        end
        $display("test_reset_with_recover: reset won over recovery");
    endtask

`ifdef RMT_REPAIR_PERF_EN
    task automatic test_perf_counters();
        reset = 1'b1;
        recoverFlag = 1'b0;
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (repairEvents !== 32'd0 || repairCycles !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got events=%0d cycles=%0d required 0 0", repairEvents, repairCycles);
        end
        nextCycle();
        for (int i = 0; i < 40; i++) begin
            recoverFlag = (i == 0 || i == 20);
            nextCycle();
        end
        recoverFlag = 1'b0;
        @(negedge clk);
        checks++;
        if (repairEvents !== 32'd2 || repairCycles !== 32'd36) begin
            errors++;
            $display("FAIL perf_counts: got events=%0d cycles=%0d required 2 36", repairEvents, repairCycles);
        end
        nextCycle();
        $display("test_perf_counters: two recoveries counted");
    endtask
`endif

    initial begin
        reset = 1'b1;
        recoverFlag = 1'b0;
        test_reset();
        test_single_walk();
        test_restart();
        test_restart_last_beat();
        test_reset_mid_walk();
        test_reset_with_recover();
`ifdef RMT_REPAIR_PERF_EN
        test_perf_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
